// File: rtl/ihadamard_16pt_stream.sv
// Streaming inverse 16-point Walsh-Hadamard transform: 16 coefficients in, four in-place butterfly stages, 16 rounded samples out.
// Define IHT_SAT_EN to clamp out-of-range samples and report them on sat_flag; otherwise samples wrap and sat_flag stays 0.
module ihadamard_16pt_stream #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             sat_flag
);
  localparam int BW = IN_W + 4;
  localparam logic signed [BW:0] MAX_V = (BW+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [BW:0] MIN_V = (BW+1)'(-(2**(OUT_W-1)));

  typedef enum logic [1:0] {LOAD = 2'd0, BFLY = 2'd1, OUT = 2'd2} state_t;

  state_t               state;
  logic [3:0]           cnt;
  logic [1:0]           stage;
  logic signed [BW-1:0] bank [16];
  logic signed [BW-1:0] bfly_next [16];
  logic [3:0]           mask;
  logic signed [BW-1:0] src;
  logic signed [BW:0]   rnd_sum;
  logic signed [BW:0]   rnd;
  logic [OUT_W-1:0]     samp;
  logic                 samp_ovf;

  // Stage s pairs i (bit s clear) with j = i|mask: i gets the sum, j the difference.
  assign mask = 4'd1 << stage;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      bfly_next[i] = '0;
      if ((4'(i) & mask) == 4'd0)
        bfly_next[i] = bank[i] + bank[4'(i) | mask];
      else
        bfly_next[i] = bank[4'(i) & ~mask] - bank[i];
    end
  end

  // Next sample to present: the first result straight out of the last stage, otherwise the following bank entry.
  assign src      = (state == BFLY) ? bfly_next[0] : bank[cnt + 4'd1];
  assign rnd_sum  = {src[BW-1], src} + (BW+1)'(8);
  assign rnd      = rnd_sum >>> 4;
  assign samp_ovf = (rnd > MAX_V) || (rnd < MIN_V);

`ifdef IHT_SAT_EN
  assign samp = !samp_ovf ? rnd[OUT_W-1:0]
              : rnd[BW]   ? {1'b1, {(OUT_W-1){1'b0}}}
              :             {1'b0, {(OUT_W-1){1'b1}}};
`else
  assign samp = rnd[OUT_W-1:0];
`endif

  // Handshakes: a beat occurs on a rising edge where valid && ready; valid/data stay stable while ready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      cnt       <= '0;
      stage     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      sat_flag  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              state    <= BFLY;
              stage    <= '0;
              cnt      <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        BFLY: begin
          stage <= stage + 2'd1;
          if (stage == 2'd3) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_data  <= samp;
`ifdef IHT_SAT_EN
            sat_flag  <= sat_flag | samp_ovf;
`else
            sat_flag  <= sat_flag & samp_ovf;  // holds its reset value of 0
`endif
          end
        end
        OUT: begin
          if (out_ready) begin
            if (cnt == 4'd15) begin
              state     <= LOAD;
              cnt       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              sat_flag  <= 1'b0;
            end else begin
              cnt      <= cnt + 4'd1;
              out_data <= samp;
              out_last <= (cnt == 4'd14);
`ifdef IHT_SAT_EN
              sat_flag <= sat_flag | samp_ovf;
`else
              sat_flag <= sat_flag & samp_ovf;
`endif
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Coefficient storage carries no reset: a frame is always fully reloaded before use.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid && in_ready)
      bank[cnt] <= BW'($signed(in_data));
    else if (state == BFLY)
      for (int i = 0; i < 16; i++) bank[i] <= bfly_next[i];
  end

endmodule
